// File: rtl/riscv_csr_pkg.sv
// ----------------------------------------------------------------------------
// riscv_csr_pkg
// Shared definitions for the RV32I machine-mode CSR file:
//   - CSR access-type encodings (none / read / read-write / read-set / read-clear)
//   - CSR address constants
//   - mstatus bit positions
//   - trap request struct
//   - csr_apply(): computes the value a write/set/clear access commits
// ----------------------------------------------------------------------------
package riscv_csr_pkg;

    // Access types as produced by the ALU from the decoded CSR instruction
    localparam logic [2:0] ACC_NONE = 3'd0;
    localparam logic [2:0] ACC_READ = 3'd2;
    localparam logic [2:0] ACC_RW   = 3'd3;
    localparam logic [2:0] ACC_RS   = 3'd6;
    localparam logic [2:0] ACC_RC   = 3'd7;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus bit positions
    localparam int MSTATUS_MIE_BIT    = 3;
    localparam int MSTATUS_MPIE_BIT   = 7;
    localparam int MSTATUS_MPP_LO_BIT = 11;
    localparam int MSTATUS_MPP_HI_BIT = 12;

    // Trap request presented by the pipeline
    typedef struct packed {
        logic        valid;
        logic        interrupt;
        logic [3:0]  cause;
        logic [31:0] pc;
        logic [31:0] value;
    } trap_t;

    // Value committed by a write-type access given the current CSR contents.
    // Non-write access types return old so callers never see an X path.
    function automatic logic [31:0] csr_apply(input logic [2:0]  acc,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        logic [31:0] result;
        case (acc)
            ACC_RW:  result = wdata;
            ACC_RS:  result = old | wdata;
            ACC_RC:  result = old & ~wdata;
            default: result = old;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/riscv_csr_counter_64.sv
// ----------------------------------------------------------------------------
// riscv_csr_counter_64
// 64-bit free-running counter with per-half CSR write access.
// A write to either half takes precedence over the increment in that cycle:
// the written half loads i_wr_data and the other half holds.
// Ports:
//   clk        core clock
//   reset      asynchronous active-high reset (count -> 0)
//   i_inc      increment enable (wraps 2^64-1 -> 0)
//   i_wr_lo    load bits [31:0] from i_wr_data
//   i_wr_hi    load bits [63:32] from i_wr_data
//   i_wr_data  write data
//   o_value    current count
// ----------------------------------------------------------------------------
module riscv_csr_counter_64 (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wr_data,
    output logic [63:0] o_value
);

    logic [63:0] r_count;
    logic [63:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_wr_lo) begin
            w_count_next[31:0] = i_wr_data;
        end else if (i_wr_hi) begin
            w_count_next[63:32] = i_wr_data;
        end else if (i_inc) begin
            w_count_next = r_count + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 64'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_value = r_count;

endmodule

// File: rtl/riscv_i32_csr.sv
// ----------------------------------------------------------------------------
// riscv_i32_csr
// Machine-mode CSR file for the RV32I core: mstatus (MIE/MPIE, MPP fixed to M),
// mtvec (direct only), mscratch, mepc, mcause, mtval, mcycle/cycle,
// minstret/instret and mhartid (reads 0).
//
// Configuration macro: RISCV_I32_CSR_INSTRET_EN
//   defined   -> minstret counter is built
//   undefined -> instret/minstret addresses read 0, writes are ignored,
//                instruction_retired is unused
//
// Ports:
//   clk, reset                 core clock, asynchronous active-high reset
//   csr_access__access/address access type and CSR address
//   csr_write_data             rs1 value or zero-extended uimm
//   instruction_retired        one pulse per retired instruction
//   trap__*                    trap request (valid, interrupt, cause, pc, value)
//   mret                       MRET executing this cycle
//   csr_read_data              old CSR value (combinational, 0 if illegal/none)
//   csr_illegal                access faults (combinational)
//   csrs__mtvec/mepc/mie       state presented to fetch/trap logic
// ----------------------------------------------------------------------------
module riscv_i32_csr
    import riscv_csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  csr_access__access,
    input  logic [11:0] csr_access__address,
    input  logic [31:0] csr_write_data,
    input  logic        instruction_retired,
    input  logic        trap__valid,
    input  logic        trap__interrupt,
    input  logic [3:0]  trap__cause,
    input  logic [31:0] trap__pc,
    input  logic [31:0] trap__value,
    input  logic        mret,
    output logic [31:0] csr_read_data,
    output logic        csr_illegal,
    output logic [31:0] csrs__mtvec,
    output logic [31:0] csrs__mepc,
    output logic        csrs__mie
);

    trap_t       w_trap;
    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_mstatus;
    logic [31:0] w_old;
    logic        w_impl;
    logic        w_readonly;
    logic        w_active;
    logic        w_illegal;
    logic        w_is_write;
    logic        w_wr_en;
    logic [31:0] w_wval;

    assign w_trap = '{valid:     trap__valid,
                      interrupt: trap__interrupt,
                      cause:     trap__cause,
                      pc:        trap__pc,
                      value:     trap__value};

    // mstatus view: only MIE/MPIE are stored, MPP is hardwired to machine mode
    always_comb begin
        w_mstatus = 32'd0;
        w_mstatus[MSTATUS_MIE_BIT]  = r_mie;
        w_mstatus[MSTATUS_MPIE_BIT] = r_mpie;
        w_mstatus[MSTATUS_MPP_HI_BIT:MSTATUS_MPP_LO_BIT] = 2'b11;
    end

    // Address decode and read mux
    always_comb begin
        w_impl = 1'b1;
        w_old  = 32'd0;
        case (csr_access__address)
            CSR_MSTATUS:   w_old = w_mstatus;
            CSR_MTVEC:     w_old = r_mtvec;
            CSR_MSCRATCH:  w_old = r_mscratch;
            CSR_MEPC:      w_old = r_mepc;
            CSR_MCAUSE:    w_old = r_mcause;
            CSR_MTVAL:     w_old = r_mtval;
            CSR_MCYCLE,
            CSR_CYCLE:     w_old = w_mcycle[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:    w_old = w_mcycle[63:32];
            CSR_MINSTRET,
            CSR_INSTRET:   w_old = w_minstret[31:0];
            CSR_MINSTRETH,
            CSR_INSTRETH:  w_old = w_minstret[63:32];
            CSR_MHARTID:   w_old = 32'd0;
            default:       w_impl = 1'b0;
        endcase
    end

    assign w_readonly = (csr_access__address[11:10] == 2'b11);
    assign w_active   = (csr_access__access != ACC_NONE);
    assign w_illegal  = w_active &&
                        (!w_impl || (w_readonly && csr_access__access != ACC_READ));
    assign w_is_write = (csr_access__access == ACC_RW) ||
                        (csr_access__access == ACC_RS) ||
                        (csr_access__access == ACC_RC);

    // Trap and MRET pre-empt the CSR write; read data and illegal are unaffected
    assign w_wr_en = w_is_write && !w_illegal && !w_trap.valid && !mret;
    assign w_wval  = csr_apply(csr_access__access, w_old, csr_write_data);

    assign csr_read_data = (w_active && !w_illegal) ? w_old : 32'd0;
    assign csr_illegal   = w_illegal;

    // Counters: increment is unconditional, a CSR write replaces it
    riscv_csr_counter_64 u_mcycle (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (1'b1),
        .i_wr_lo   (w_wr_en && (csr_access__address == CSR_MCYCLE)),
        .i_wr_hi   (w_wr_en && (csr_access__address == CSR_MCYCLEH)),
        .i_wr_data (w_wval),
        .o_value   (w_mcycle)
    );

`ifdef RISCV_I32_CSR_INSTRET_EN
    riscv_csr_counter_64 u_minstret (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (instruction_retired),
        .i_wr_lo   (w_wr_en && (csr_access__address == CSR_MINSTRET)),
        .i_wr_hi   (w_wr_en && (csr_access__address == CSR_MINSTRETH)),
        .i_wr_data (w_wval),
        .o_value   (w_minstret)
    );
`else
    // No storage: addresses stay decoded so accesses are legal and read 0
    logic w_unused_retired;
    assign w_unused_retired = instruction_retired;
    assign w_minstret       = 64'd0;
`endif

    // Trap state and machine CSRs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= 32'd0;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
        end else if (w_trap.valid) begin
            r_mepc   <= {w_trap.pc[31:1], 1'b0};
            r_mcause <= {w_trap.interrupt, 27'd0, w_trap.cause};
            r_mtval  <= w_trap.value;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_en) begin
            case (csr_access__address)
                CSR_MSTATUS: begin
                    r_mie  <= w_wval[MSTATUS_MIE_BIT];
                    r_mpie <= w_wval[MSTATUS_MPIE_BIT];
                end
                CSR_MTVEC:    r_mtvec    <= {w_wval[31:2], 2'b00};
                CSR_MSCRATCH: r_mscratch <= w_wval;
                CSR_MEPC:     r_mepc     <= {w_wval[31:1], 1'b0};
                CSR_MCAUSE:   r_mcause   <= w_wval;
                CSR_MTVAL:    r_mtval    <= w_wval;
                default: ;   // counters handled in their own instances
            endcase
        end
    end

    assign csrs__mtvec = r_mtvec;
    assign csrs__mepc  = r_mepc;
    assign csrs__mie   = r_mie;

endmodule
